// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } tx_state_e;

  localparam logic [1:0]  ADDR_ILLEGAL = 2'd3;
  localparam int unsigned HDR_LEN_LSB  = 2;
  localparam int unsigned MAX_PAYLOAD  = 63;

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: synchronous write, registered read (read-before-write on a same-slot collision).
module router_tx_buf
  import router_pkg::*;
#(
  parameter int unsigned AW    = 6,
  parameter int unsigned DEPTH = 64
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: buffers a payload, then sends header/payload/parity.
// Optional ROUTER_TX_ERR_INJECT_EN adds inj_parity to send an inverted parity byte.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned LEN_W      = 6,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             pl_valid,
  input  logic [7:0]       pl_data,
  output logic             pl_ready,
  input  logic             busy,
  output logic             packet_valid,
  output logic [7:0]       data_out,
  output logic             tx_done,
`ifdef ROUTER_TX_ERR_INJECT_EN
  input  logic             inj_parity,
`endif
  output logic             req_err
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  tx_state_e        state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             pl_ready_q, pl_ready_d;
  logic             pv_q, pv_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             req_err_q, req_err_d;
  logic [7:0]       hdr_q, hdr_d;
  logic [7:0]       parity_q, parity_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             inj_q, inj_d;

  logic [7:0]       hdr_in;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       parity_tx;
  logic [7:0]       rd_data;
  logic             pl_fire;

  always_comb begin
    hdr_in                         = '0;
    hdr_in[7:HDR_LEN_LSB]          = req_len;
    hdr_in[HDR_LEN_LSB-1:0]        = req_addr;
  end

  assign len_q   = hdr_q[7:HDR_LEN_LSB];
  assign pl_fire = pl_valid && pl_ready_q;

`ifdef ROUTER_TX_ERR_INJECT_EN
  assign parity_tx = inj_q ? ~parity_q : parity_q;
`else
  assign parity_tx = parity_q;
`endif

  // Read address follows rd_cnt_d, so rd_data already holds buf[rd_cnt_q] when it is loaded.
  router_tx_buf #(
    .AW    (LEN_W),
    .DEPTH (MAX_PAYLOAD + 1)
  ) u_buf (
    .clk     (clk),
    .wr_en   (pl_fire),
    .wr_addr (wr_cnt_q),
    .wr_data (pl_data),
    .rd_addr (rd_cnt_d),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    pl_ready_d  = 1'b0;
    pv_d        = pv_q;
    data_out_d  = data_out_q;
    req_err_d   = 1'b0;
    hdr_d       = hdr_q;
    parity_d    = parity_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    inj_d       = inj_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          if (req_len == '0 || req_addr == ADDR_ILLEGAL) begin
            req_err_d = 1'b1;
          end else begin
            hdr_d       = hdr_in;
            parity_d    = hdr_in;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            state_d     = LOAD;
            req_ready_d = 1'b0;
            pl_ready_d  = 1'b1;
`ifdef ROUTER_TX_ERR_INJECT_EN
            inj_d       = inj_parity;
`endif
          end
        end
      end
      LOAD: begin
        if (pl_fire) begin
          parity_d = parity_q ^ pl_data;
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
        pl_ready_d = (wr_cnt_d != len_q);
        // One settle cycle after the last write so the registered read of slot 0 is fresh.
        if (wr_cnt_q == len_q) begin
          state_d    = HEADER;
          pv_d       = 1'b1;
          data_out_d = hdr_q;
        end
      end
      HEADER: begin
        if (!busy) begin
          data_out_d = rd_data;
          rd_cnt_d   = rd_cnt_q + 1'b1;
          state_d    = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          if (rd_cnt_q == len_q) begin
            pv_d       = 1'b0;
            data_out_d = parity_tx;
            state_d    = PARITY;
          end else begin
            data_out_d = rd_data;
            rd_cnt_d   = rd_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          data_out_d = '0;
          gap_cnt_d  = '0;
          if (GAP_CYCLES == 0) begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      pl_ready_q  <= 1'b0;
      pv_q        <= 1'b0;
      data_out_q  <= '0;
      req_err_q   <= 1'b0;
      hdr_q       <= '0;
      parity_q    <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      inj_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      pl_ready_q  <= pl_ready_d;
      pv_q        <= pv_d;
      data_out_q  <= data_out_d;
      req_err_q   <= req_err_d;
      hdr_q       <= hdr_d;
      parity_q    <= parity_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      inj_q       <= inj_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign pl_ready     = pl_ready_q;
  assign packet_valid = pv_q;
  assign data_out     = data_out_q;
  assign req_err      = req_err_q;
  // tx_done marks the acceptance cycle itself, so it follows busy within the cycle.
  assign tx_done      = (state_q == PARITY) && !busy;

endmodule
